cdb_reservation_station: RTL and testbench

//  Single-entry reservation station that consumes CDB broadcasts, i.e. the listening end of the CDB arbiter.

---
 rtl/cdb_reservation_station.sv | 127 ++++++++++++
 tb/tb_cdb_reservation_station.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_reservation_station.sv
// Single-entry reservation station: captures an issued op, snoops the CDB for
// pending operand tags, dispatches to the FU and holds the entry until retired.
module cdb_reservation_station #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 3,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [OP_WIDTH-1:0]   issue_op,
  input  logic                  issue_a_pending,
  input  logic [TAG_WIDTH-1:0]  issue_a_tag,
  input  logic [DATA_WIDTH-1:0] issue_a_value,
  input  logic                  issue_b_pending,
  input  logic [TAG_WIDTH-1:0]  issue_b_tag,
  input  logic [DATA_WIDTH-1:0] issue_b_value,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_rs_id,
  input  logic [DATA_WIDTH-1:0] cdb_result,
  output logic                  dispatch_valid,
  input  logic                  dispatch_ready,
  output logic [OP_WIDTH-1:0]   dispatch_op,
  output logic [DATA_WIDTH-1:0] dispatch_a,
  output logic [DATA_WIDTH-1:0] dispatch_b,
  input  logic                  retire,
  output logic                  busy
);

  // Handshakes: issue transfers on issue_valid && issue_ready; dispatch transfers
  // on dispatch_valid && dispatch_ready, with op/operands held stable until then.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    READY    = 2'd2,
    EXEC     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [TAG_WIDTH-1:0]  a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic                  a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic                  a_hit_issue, b_hit_issue, a_hit_wait, b_hit_wait;

  always_comb begin
    a_hit_issue = issue_a_pending && cdb_valid && (issue_a_tag == cdb_rs_id);
    b_hit_issue = issue_b_pending && cdb_valid && (issue_b_tag == cdb_rs_id);
    a_hit_wait  = a_pend_q && cdb_valid && (a_tag_q == cdb_rs_id);
    b_hit_wait  = b_pend_q && cdb_valid && (b_tag_q == cdb_rs_id);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    a_tag_d  = a_tag_q;
    b_tag_d  = b_tag_q;
    a_pend_d = a_pend_q;
    b_pend_d = b_pend_q;
    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          op_d     = issue_op;
          a_tag_d  = issue_a_tag;
          b_tag_d  = issue_b_tag;
          // A broadcast in the issue cycle is captured directly so it is not missed.
          a_d      = a_hit_issue ? cdb_result : issue_a_value;
          b_d      = b_hit_issue ? cdb_result : issue_b_value;
          a_pend_d = issue_a_pending && !a_hit_issue;
          b_pend_d = issue_b_pending && !b_hit_issue;
          state_d  = (a_pend_d || b_pend_d) ? WAIT_OPS : READY;
        end
      end
      WAIT_OPS: begin
        if (a_hit_wait) begin
          a_d      = cdb_result;
          a_pend_d = 1'b0;
        end
        if (b_hit_wait) begin
          b_d      = cdb_result;
          b_pend_d = 1'b0;
        end
        if (!a_pend_d && !b_pend_d) state_d = READY;
      end
      READY: begin
        if (dispatch_ready) state_d = EXEC;
      end
      EXEC: begin
        if (retire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_tag_q  <= '0;
      b_tag_q  <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_tag_q  <= a_tag_d;
      b_tag_q  <= b_tag_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
    end
  end

  assign issue_ready    = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign dispatch_valid = (state_q == READY);
  assign dispatch_op    = op_q;
  assign dispatch_a     = a_q;
  assign dispatch_b     = b_q;

endmodule

// File: tb/tb_cdb_reservation_station.sv
// Bench for cdb_reservation_station: directed scenarios plus a scoreboard that
// checks every dispatched op/operand bundle against the expected queue.
module tb_cdb_reservation_station;
  localparam int DW = 64;
  localparam int TW = 3;
  localparam int OW = 4;
  localparam int W  = OW + 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [OW-1:0] issue_op = '0;
  logic          issue_a_pending = 1'b0;
  logic [TW-1:0] issue_a_tag = '0;
  logic [DW-1:0] issue_a_value = '0;
  logic          issue_b_pending = 1'b0;
  logic [TW-1:0] issue_b_tag = '0;
  logic [DW-1:0] issue_b_value = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_rs_id = '0;
  logic [DW-1:0] cdb_result = '0;
  logic          dispatch_valid;
  logic          dispatch_ready = 1'b0;
  logic [OW-1:0] dispatch_op;
  logic [DW-1:0] dispatch_a;
  logic [DW-1:0] dispatch_b;
  logic          retire = 1'b0;
  logic          busy;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  cdb_reservation_station #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a_pending(issue_a_pending), .issue_a_tag(issue_a_tag), .issue_a_value(issue_a_value),
    .issue_b_pending(issue_b_pending), .issue_b_tag(issue_b_tag), .issue_b_value(issue_b_value),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_a(dispatch_a), .dispatch_b(dispatch_b),
    .retire(retire), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: every accepted dispatch must match the oldest expected bundle
  always @(negedge clk) begin
    if (rst_n && dispatch_valid && dispatch_ready) begin
      if (exp_q.size() == 0) check("dispatch_unexpected", 1, 0);
      else check("dispatch_bundle", {dispatch_op, dispatch_a, dispatch_b}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OW-1:0] op,
                       input logic ap, input logic [TW-1:0] at, input logic [DW-1:0] av,
                       input logic bp, input logic [TW-1:0] bt, input logic [DW-1:0] bv,
                       input logic push, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    issue_valid = 1'b1;
    issue_op = op;
    issue_a_pending = ap; issue_a_tag = at; issue_a_value = av;
    issue_b_pending = bp; issue_b_tag = bt; issue_b_value = bv;
    if (push) exp_q.push_back({op, ea, eb});
    tick();
    issue_valid = 1'b0;
    issue_a_pending = 1'b0;
    issue_b_pending = 1'b0;
  endtask

  task automatic broadcast(input logic v, input logic [TW-1:0] id, input logic [DW-1:0] r);
    cdb_valid = v; cdb_rs_id = id; cdb_result = r;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    check({tag, "_exec_dv"}, dispatch_valid, 0);
    check({tag, "_exec_busy"}, busy, 1);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check({tag, "_idle_ready"}, issue_ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    logic [OW-1:0] rop;
    logic [TW-1:0] rt;

    // reset state
    tick(); tick();
    check("rst_issue_ready", issue_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dv", dispatch_valid, 0);
    check("rst_regs", {dispatch_op, dispatch_a, dispatch_b}, 0);
    rst_n = 1'b1;
    tick();

    // 1: no pending operands
    issue(4'd3, 0, 0, 64'd5, 0, 0, 64'd7, 1, 64'd5, 64'd7);
    check("t1_dv", dispatch_valid, 1);
    check("t1_issue_ready", issue_ready, 0);
    check("t1_a", dispatch_a, 64'd5);
    check("t1_b", dispatch_b, 64'd7);
    finish_op("t1");

    // 2: A pending on tag 2, foreign broadcast ignored
    issue(4'd1, 1, 3'd2, 64'd0, 0, 0, 64'd9, 1, 64'hAB, 64'd9);
    check("t2_wait_dv", dispatch_valid, 0);
    check("t2_wait_busy", busy, 1);
    broadcast(1, 3'd4, 64'h55);
    tick(); tick();
    check("t2_foreign_dv", dispatch_valid, 0);
    broadcast(1, 3'd2, 64'hAB);
    check("t2_dv", dispatch_valid, 1);
    check("t2_a", dispatch_a, 64'hAB);
    check("t2_b", dispatch_b, 64'd9);
    finish_op("t2");

    // 3: bypass capture in the issue cycle
    cdb_valid = 1'b1; cdb_rs_id = 3'd1; cdb_result = 64'h11;
    issue(4'd2, 1, 3'd1, 64'd0, 0, 0, 64'h22, 1, 64'h11, 64'h22);
    cdb_valid = 1'b0;
    check("t3_dv", dispatch_valid, 1);
    check("t3_a", dispatch_a, 64'h11);
    finish_op("t3");

    // 4: both operands on tag 5, invalid broadcast first
    issue(4'd4, 1, 3'd5, 64'd0, 1, 3'd5, 64'd0, 1, 64'h3C, 64'h3C);
    broadcast(0, 3'd5, 64'h99);
    check("t4_invalid_dv", dispatch_valid, 0);
    broadcast(1, 3'd5, 64'h3C);
    check("t4_dv", dispatch_valid, 1);
    check("t4_a", dispatch_a, 64'h3C);
    check("t4_b", dispatch_b, 64'h3C);
    finish_op("t4");

    // 5: stalled in READY, CDB traffic and retire pulses ignored
    issue(4'd6, 0, 0, 64'h1234, 0, 0, 64'h5678, 1, 64'h1234, 64'h5678);
    for (int i = 0; i < 4; i++) begin
      cdb_valid = 1'b1;
      cdb_rs_id = 3'($urandom_range(0, 7));
      cdb_result = {$urandom, $urandom};
      retire = i[0];
      tick();
      check("t5_hold_dv", dispatch_valid, 1);
      check("t5_hold_bundle", {dispatch_op, dispatch_a, dispatch_b}, {4'd6, 64'h1234, 64'h5678});
    end
    cdb_valid = 1'b0;
    retire = 1'b0;
    finish_op("t5");

    // 6: async reset while waiting, later matching broadcast has no effect
    issue(4'd7, 1, 3'd3, 64'd0, 0, 0, 64'd1, 0, 64'd0, 64'd0);
    check("t6_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_ready", issue_ready, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_dv", dispatch_valid, 0);
    tick();
    rst_n = 1'b1;
    broadcast(1, 3'd3, 64'h77);
    tick();
    check("t6_post_busy", busy, 0);
    check("t6_post_dv", dispatch_valid, 0);
    check("t6_post_a", dispatch_a, 0);

    // random ops: A pending on a random tag, B immediate
    for (int i = 0; i < 4; i++) begin
      rop = 4'($urandom_range(0, 15));
      rt  = 3'($urandom_range(0, 7));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      issue(rop, 1, rt, 64'd0, 0, 0, rb, 1, ra, rb);
      broadcast(1, rt + 3'd1, ~ra);
      check("rnd_wait_dv", dispatch_valid, 0);
      broadcast(1, rt, ra);
      check("rnd_dv", dispatch_valid, 1);
      finish_op("rnd");
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
